// File: rtl/tx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// | Module   : tx_fifo_pkg                                                   |
// | Purpose  : Shared defaults and drain-state encoding for tx_fifo_bridge.  |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

package tx_fifo_pkg;

  localparam int TX_FIFO_DATA_WIDTH = 8;
  localparam int TX_FIFO_DEPTH      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    DRAIN = 2'b10
  } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/tx_fifo_mem.sv
// ----------------------------------------------------------------------------
// | Module   : tx_fifo_mem                                                   |
// | Purpose  : DEPTH x DATA_WIDTH register array, sync write, comb read.     |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

module tx_fifo_mem
  import tx_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = TX_FIFO_DATA_WIDTH,
  parameter int  DEPTH      = TX_FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Storage is deliberately not reset; occupancy is tracked by the pointers.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/tx_fifo_bridge.sv
// ----------------------------------------------------------------------------
// | Module   : tx_fifo_bridge                                                |
// | Purpose  : Byte FIFO between controller and UART TX with drain FSM.      |
// |            Define TX_FIFO_STATUS_EN to add FIFO_LEVEL and OVERFLOW.      |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

module tx_fifo_bridge
  import tx_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = TX_FIFO_DATA_WIDTH,
  parameter int  DEPTH      = TX_FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_INC,
  output logic                  FIFO_FULL,
  output logic                  FIFO_EMPTY,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID
`ifdef TX_FIFO_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   FIFO_LEVEL,
  output logic                  OVERFLOW
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  drain_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;

  // Flags come only from registered pointers, so a launch never frees a slot in the same cycle.
  assign FIFO_EMPTY = (wr_ptr_q == rd_ptr_q);
  assign FIFO_FULL  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                      (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign wr_en      = WR_INC && !FIFO_FULL;

  tx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (WR_DATA),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    case (state_q)
      IDLE: begin
        if (!FIFO_EMPTY && !TX_BUSY) begin
          state_d    = SEND;
          tx_data_d  = rd_data;
          tx_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
        end
      end
      SEND: begin
        if (TX_BUSY) begin
          state_d    = DRAIN;
          tx_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (!TX_BUSY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign TX_P_DATA     = tx_data_q;
  assign TX_DATA_VALID = tx_valid_q;

`ifdef TX_FIFO_STATUS_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | (WR_INC & FIFO_FULL);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign FIFO_LEVEL = wr_ptr_q - rd_ptr_q;
  assign OVERFLOW   = overflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_fifo_bridge.sv
// ----------------------------------------------------------------------------
// | Module   : tb_tx_fifo_bridge                                             |
// | Purpose  : Self-checking bench for tx_fifo_bridge against a queue model. |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tx_fifo_bridge;

  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       WR_INC = 1'b0;
  logic       FIFO_FULL, FIFO_EMPTY;
  logic       TX_BUSY = 1'b0;
  logic [7:0] TX_P_DATA;
  logic       TX_DATA_VALID;
`ifdef TX_FIFO_STATUS_EN
  logic [3:0] FIFO_LEVEL;
  logic       OVERFLOW;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rx_q[$];

  tx_fifo_bridge dut (
    .CLK           (CLK),
    .RST           (RST),
    .WR_DATA       (WR_DATA),
    .WR_INC        (WR_INC),
    .FIFO_FULL     (FIFO_FULL),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .TX_BUSY       (TX_BUSY),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID)
`ifdef TX_FIFO_STATUS_EN
    ,
    .FIFO_LEVEL    (FIFO_LEVEL),
    .OVERFLOW      (OVERFLOW)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    WR_INC  = 1'b0;
    WR_DATA = 8'h00;
    TX_BUSY = 1'b0;
    #2;
    RST = 1'b0;
    repeat (2) step();
    RST = 1'b1;
  endtask

  // Simple UART stand-in: accept each presented byte, pulse busy, release.
  task automatic collect(input int n, input int max_cyc, output int timed_out);
    int cyc;
    rx_q.delete();
    TX_BUSY = 1'b0;
    cyc = 0;
    while (rx_q.size() < n && cyc < max_cyc) begin
      step();
      cyc++;
      if (TX_DATA_VALID && !TX_BUSY) begin
        rx_q.push_back(TX_P_DATA);
        TX_BUSY = 1'b1;
      end else if (TX_BUSY && !TX_DATA_VALID) begin
        TX_BUSY = 1'b0;
      end
    end
    step();
    TX_BUSY = 1'b0;
    step();
    timed_out = (rx_q.size() < n) ? 1 : 0;
  endtask

  task automatic test_reset();
    WR_INC = 1'b0; TX_BUSY = 1'b0;
    RST = 1'b0;
    repeat (2) step();
    n_checks++;
    if (TX_DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", TX_DATA_VALID); end
    n_checks++;
    if (TX_P_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", TX_P_DATA); end
    n_checks++;
    if (FIFO_EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", FIFO_EMPTY); end
    n_checks++;
    if (FIFO_FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", FIFO_FULL); end
`ifdef TX_FIFO_STATUS_EN
    n_checks++;
    if (FIFO_LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", FIFO_LEVEL); end
    n_checks++;
    if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", OVERFLOW); end
`endif
    RST = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    WR_DATA = 8'h5A; WR_INC = 1'b1;
    step();
    WR_INC = 1'b0;
    n_checks++;
    if (TX_DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", TX_DATA_VALID); end
    n_checks++;
    if (FIFO_EMPTY !== 1'b0) begin n_fail++; $display("FAIL single_stored: empty got %b expected 0", FIFO_EMPTY); end
    step();
    n_checks++;
    if (TX_DATA_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", TX_DATA_VALID); end
    n_checks++;
    if (TX_P_DATA !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h expected 5a", TX_P_DATA); end
    n_checks++;
    if (FIFO_EMPTY !== 1'b1) begin n_fail++; $display("FAIL single_empty_after_launch: got %b expected 1", FIFO_EMPTY); end
    TX_BUSY = 1'b1;
    step();
    n_checks++;
    if (TX_DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", TX_DATA_VALID); end
    n_checks++;
    if (TX_P_DATA !== 8'h5A) begin n_fail++; $display("FAIL single_data_keep: got %h expected 5a", TX_P_DATA); end
    TX_BUSY = 1'b0;
    repeat (3) step();
    n_checks++;
    if (TX_DATA_VALID !== 1'b0 || FIFO_EMPTY !== 1'b1) begin
      n_fail++; $display("FAIL single_idle: valid %b empty %b expected 0 1", TX_DATA_VALID, FIFO_EMPTY);
    end
  endtask

  task automatic test_full_overflow();
    int to;
    apply_reset();
    TX_BUSY = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      WR_DATA = 8'(i); WR_INC = 1'b1;
      step();
      n_checks++;
      if (FIFO_FULL !== (i == DEPTH)) begin
        n_fail++; $display("FAIL full_flag_w%0d: got %b expected %b", i, FIFO_FULL, (i == DEPTH));
      end
    end
`ifdef TX_FIFO_STATUS_EN
    n_checks++;
    if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", OVERFLOW); end
`endif
    WR_DATA = 8'hFF; WR_INC = 1'b1;
    step();
    WR_INC = 1'b0;
    n_checks++;
    if (FIFO_FULL !== 1'b1 || FIFO_EMPTY !== 1'b0) begin
      n_fail++; $display("FAIL full_after_drop: full %b empty %b expected 1 0", FIFO_FULL, FIFO_EMPTY);
    end
`ifdef TX_FIFO_STATUS_EN
    n_checks++;
    if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", OVERFLOW); end
    n_checks++;
    if (FIFO_LEVEL !== 4'd8) begin n_fail++; $display("FAIL full_level: got %0d expected 8", FIFO_LEVEL); end
`endif
    collect(DEPTH, 200, to);
    n_checks++;
    if (to != 0) begin n_fail++; $display("FAIL full_drain_timeout: got %0d bytes expected %0d", rx_q.size(), DEPTH); end
    for (int i = 0; i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL full_order_%0d: got %h expected %h", i, rx_q[i], 8'(i + 1)); end
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (TX_DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL full_dropped_byte_sent: data %h", TX_P_DATA); end
    end
    n_checks++;
    if (FIFO_EMPTY !== 1'b1) begin n_fail++; $display("FAIL full_final_empty: got %b expected 1", FIFO_EMPTY); end
`ifdef TX_FIFO_STATUS_EN
    n_checks++;
    if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", OVERFLOW); end
`endif
  endtask

  task automatic test_stream();
    logic [7:0] exp_q[$];
    logic [7:0] exp_b, held;
    logic       acc, prev_valid;
    int sent, received, cyc, wait_cnt, hold;
    apply_reset();
    sent = 0; received = 0; cyc = 0; wait_cnt = 0; hold = 0;
    prev_valid = 1'b0; held = 8'h00;
    while ((received < 20) && cyc < 3000) begin
      if (sent < 20 && $urandom_range(0, 3) != 0) begin
        WR_INC = 1'b1; WR_DATA = 8'($urandom);
      end else begin
        WR_INC = 1'b0;
      end
      acc = WR_INC && (exp_q.size() < DEPTH);
      step();
      cyc++;
      if (TX_DATA_VALID && !prev_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_spurious: got %h expected no byte", TX_P_DATA);
        end else begin
          exp_b = exp_q.pop_front();
          if (TX_P_DATA !== exp_b) begin n_fail++; $display("FAIL stream_byte_%0d: got %h expected %h", received, TX_P_DATA, exp_b); end
        end
        received++;
        held = TX_P_DATA;
        wait_cnt = $urandom_range(0, 2);
      end else if (TX_DATA_VALID) begin
        n_checks++;
        if (TX_P_DATA !== held) begin n_fail++; $display("FAIL stream_hold: got %h expected %h", TX_P_DATA, held); end
      end
      if (acc) begin
        exp_q.push_back(WR_DATA);
        sent++;
      end
      n_checks++;
      if (FIFO_EMPTY !== (exp_q.size() == 0) || FIFO_FULL !== (exp_q.size() == DEPTH)) begin
        n_fail++; $display("FAIL stream_flags: empty %b full %b expected count %0d", FIFO_EMPTY, FIFO_FULL, exp_q.size());
      end
`ifdef TX_FIFO_STATUS_EN
      n_checks++;
      if (FIFO_LEVEL !== 4'(exp_q.size()) || FIFO_LEVEL > 4'd8) begin
        n_fail++; $display("FAIL stream_level: got %0d expected %0d", FIFO_LEVEL, exp_q.size());
      end
`endif
      prev_valid = TX_DATA_VALID;
      if (!TX_BUSY) begin
        if (TX_DATA_VALID) begin
          if (wait_cnt == 0) begin TX_BUSY = 1'b1; hold = $urandom_range(1, 3); end
          else wait_cnt--;
        end
      end else if (!TX_DATA_VALID) begin
        if (hold == 0) TX_BUSY = 1'b0;
        else hold--;
      end
    end
    WR_INC = 1'b0;
    n_checks++;
    if (received != 20 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL stream_count: got %0d bytes (%0d left) expected 20 (0 left)", received, exp_q.size());
    end
    TX_BUSY = 1'b1; step();
    TX_BUSY = 1'b0; repeat (2) step();
  endtask

  task automatic test_simul_write_launch();
    int to;
    apply_reset();
    TX_BUSY = 1'b1;
    WR_DATA = 8'hA1; WR_INC = 1'b1;
    step();
    WR_INC = 1'b0;
    n_checks++;
    if (FIFO_EMPTY !== 1'b0 || TX_DATA_VALID !== 1'b0) begin
      n_fail++; $display("FAIL simul_pre: empty %b valid %b expected 0 0", FIFO_EMPTY, TX_DATA_VALID);
    end
    TX_BUSY = 1'b0;
    WR_DATA = 8'hB2; WR_INC = 1'b1;
    step();
    WR_INC = 1'b0;
    n_checks++;
    if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'hA1) begin
      n_fail++; $display("FAIL simul_launch: valid %b data %h expected 1 a1", TX_DATA_VALID, TX_P_DATA);
    end
    n_checks++;
    if (FIFO_EMPTY !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got %b expected 0", FIFO_EMPTY); end
`ifdef TX_FIFO_STATUS_EN
    n_checks++;
    if (FIFO_LEVEL !== 4'd1) begin n_fail++; $display("FAIL simul_level: got %0d expected 1", FIFO_LEVEL); end
`endif
    collect(2, 100, to);
    n_checks++;
    if (to != 0 || rx_q.size() != 2) begin
      n_fail++; $display("FAIL simul_count: got %0d bytes expected 2", rx_q.size());
    end else begin
      n_checks++;
      if (rx_q[0] !== 8'hA1 || rx_q[1] !== 8'hB2) begin
        n_fail++; $display("FAIL simul_bytes: got %h %h expected a1 b2", rx_q[0], rx_q[1]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    apply_reset();
    TX_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      WR_DATA = 8'h10 + 8'(i); WR_INC = 1'b1;
      step();
    end
    WR_INC = 1'b0;
    TX_BUSY = 1'b0;
    step();
    n_checks++;
    if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'h10) begin
      n_fail++; $display("FAIL mid_send: valid %b data %h expected 1 10", TX_DATA_VALID, TX_P_DATA);
    end
    #3;
    RST = 1'b0;
    #1;
    n_checks++;
    if (TX_DATA_VALID !== 1'b0 || TX_P_DATA !== 8'h00 || FIFO_EMPTY !== 1'b1 || FIFO_FULL !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: valid %b data %h empty %b full %b expected 0 00 1 0",
                         TX_DATA_VALID, TX_P_DATA, FIFO_EMPTY, FIFO_FULL);
    end
`ifdef TX_FIFO_STATUS_EN
    n_checks++;
    if (FIFO_LEVEL !== 4'd0 || OVERFLOW !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_status: level %0d ovf %b expected 0 0", FIFO_LEVEL, OVERFLOW);
    end
`endif
    #3;
    RST = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (TX_DATA_VALID !== 1'b0 || FIFO_EMPTY !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL mid_after_release: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_hold_in_send();
    int to;
    apply_reset();
    TX_BUSY = 1'b1;
    WR_DATA = 8'hC3; WR_INC = 1'b1; step();
    WR_DATA = 8'h3C; step();
    WR_INC = 1'b0;
    TX_BUSY = 1'b0;
    step();
    n_checks++;
    if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'hC3) begin
      n_fail++; $display("FAIL hold_launch: valid %b data %h expected 1 c3", TX_DATA_VALID, TX_P_DATA);
    end
    for (int c = 0; c < 50; c++) begin
      step();
      n_checks++;
      if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'hC3 || FIFO_EMPTY !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle_%0d: valid %b data %h empty %b expected 1 c3 0",
                           c, TX_DATA_VALID, TX_P_DATA, FIFO_EMPTY);
      end
`ifdef TX_FIFO_STATUS_EN
      n_checks++;
      if (FIFO_LEVEL !== 4'd1) begin n_fail++; $display("FAIL hold_level_%0d: got %0d expected 1", c, FIFO_LEVEL); end
`endif
    end
    collect(2, 100, to);
    n_checks++;
    if (to != 0 || rx_q.size() != 2) begin
      n_fail++; $display("FAIL hold_count: got %0d bytes expected 2", rx_q.size());
    end else begin
      n_checks++;
      if (rx_q[0] !== 8'hC3 || rx_q[1] !== 8'h3C) begin
        n_fail++; $display("FAIL hold_bytes: got %h %h expected c3 3c", rx_q[0], rx_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_stream();
    test_simul_write_launch();
    test_reset_midframe();
    test_hold_in_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
